// File: rtl/led_bank.sv
// N-channel status-LED driver: steady, flash and counted blink bursts with lamp-test override.
// A free-running half-period counter drives one shared phase register, so no divided or gated clock exists.
module led_bank #(
   parameter int N        = 6,
   parameter int FLA_CMAX = 25000000,
   parameter int BW       = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  ld,
   input  logic [N-1:0]  fl,
   input  logic [N-1:0]  blk_req,
   input  logic [BW-1:0] blk_cnt,
   input  logic          lamp_test,
   output logic [N-1:0]  led,
   output logic [N-1:0]  blk_busy,
   output logic          phase
);

   localparam int CW = $clog2(FLA_CMAX);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RUN
   } state_e;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          phase_q, phase_d;
   logic          tick, rise, fall;
   logic          blk_cnt_nz;

   state_e        state_q [N];
   state_e        state_d [N];
   logic [BW-1:0] brem_q  [N];
   logic [BW-1:0] brem_d  [N];

   logic [N-1:0]  led_q, led_d;
   logic [N-1:0]  busy_q, busy_d;

   always_comb begin
      tick    = (cnt_q == CW'(FLA_CMAX - 1));
      cnt_d   = tick ? '0 : cnt_q + CW'(1);
      phase_d = phase_q ^ tick;
      rise    = tick & ~phase_q;
      fall    = tick & phase_q;
   end

   assign blk_cnt_nz = (blk_cnt != '0);

   // LED mux looks at next state/phase so led flips on the same edge as phase.
   always_comb begin
      led_d  = '0;
      busy_d = '0;
      for (int unsigned i = 0; i < N; i++) begin
         state_d[i] = state_q[i];
         brem_d[i]  = brem_q[i];
         if (blk_req[i] && blk_cnt_nz) begin
            brem_d[i] = blk_cnt;
            if (state_q[i] == S_IDLE) state_d[i] = S_WAIT;
         end else begin
            case (state_q[i])
               S_WAIT: if (rise) state_d[i] = S_RUN;
               S_RUN: begin
                  if (fall) begin
                     brem_d[i] = brem_q[i] - BW'(1);
                     if (brem_q[i] == BW'(1)) state_d[i] = S_IDLE;
                  end
               end
               default: ;
            endcase
         end

         busy_d[i] = (state_d[i] != S_IDLE);

         if (lamp_test)                led_d[i] = 1'b1;
         else if (state_d[i] == S_RUN) led_d[i] = phase_d;
         else if (fl[i])               led_d[i] = phase_d;
         else                          led_d[i] = ld[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
         led_q   <= '0;
         busy_q  <= '0;
         for (int unsigned i = 0; i < N; i++) begin
            state_q[i] <= S_IDLE;
            brem_q[i]  <= '0;
         end
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
         for (int unsigned i = 0; i < N; i++) begin
            state_q[i] <= state_d[i];
            brem_q[i]  <= brem_d[i];
         end
      end
   end

   assign led      = led_q;
   assign blk_busy = busy_q;
   assign phase    = phase_q;

endmodule

// File: tb/tb_led_bank.sv
// Randomised bench for led_bank; expected outputs come from a time-based model
// (phase derived from edges since reset, bursts tracked as lit halves remaining).
module tb_led_bank;

   localparam int N  = 6;
   localparam int FC = 4;
   localparam int BW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  ld, fl, blk_req;
   logic [BW-1:0] blk_cnt;
   logic          lamp_test;
   logic [N-1:0]  led, blk_busy;
   logic          phase;

   led_bank #(.N(N), .FLA_CMAX(FC), .BW(BW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld        (ld),
      .fl        (fl),
      .blk_req   (blk_req),
      .blk_cnt   (blk_cnt),
      .lamp_test (lamp_test),
      .led       (led),
      .blk_busy  (blk_busy),
      .phase     (phase)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model state: edges since reset release, and per-channel burst bookkeeping.
   int e;
   bit active  [N];
   bit waiting [N];
   int rem     [N];
   logic [N-1:0] m_led, m_busy;
   logic         m_phase;

   function automatic bit phase_at(input int edges);
      return ((edges / FC) % 2) == 1;
   endfunction

   task automatic model_reset();
      e = 0;
      for (int i = 0; i < N; i++) begin
         active[i] = 0; waiting[i] = 0; rem[i] = 0;
      end
      m_led = '0; m_busy = '0; m_phase = 1'b0;
   endtask

   task automatic model_edge();
      bit is_rise, is_fall, p;
      e++;
      p       = phase_at(e);
      is_rise = (e % FC == 0) && p;
      is_fall = (e % FC == 0) && !p;
      for (int i = 0; i < N; i++) begin
         if (blk_req[i] && blk_cnt != 0) begin
            rem[i] = blk_cnt;
            if (!active[i]) begin
               active[i] = 1; waiting[i] = 1;
            end
         end else if (active[i]) begin
            if (waiting[i]) begin
               if (is_rise) waiting[i] = 0;
            end else if (is_fall) begin
               rem[i]--;
               if (rem[i] == 0) active[i] = 0;
            end
         end
         m_busy[i] = active[i];
         if (lamp_test)                    m_led[i] = 1'b1;
         else if (active[i] && !waiting[i]) m_led[i] = p;
         else if (fl[i])                   m_led[i] = p;
         else                              m_led[i] = ld[i];
      end
      m_phase = p;
   endtask

   task automatic check_outputs(input string where);
      chk({where, ".led"},   32'(led),      32'(m_led));
      chk({where, ".busy"},  32'(blk_busy), 32'(m_busy));
      chk({where, ".phase"}, 32'(phase),    32'(m_phase));
   endtask

   task automatic async_reset_check();
      #2 rst_n = 1'b0;
      #1;
      chk("areset.led",   32'(led),      32'h0);
      chk("areset.busy",  32'(blk_busy), 32'h0);
      chk("areset.phase", 32'(phase),    32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      rst_n = 1'b0; ld = '0; fl = '0; blk_req = '0; blk_cnt = '0; lamp_test = 1'b0;
      model_reset();
      #1;
      check_outputs("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle run: phase period and quiet outputs with all inputs low.
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); model_edge(); #1; check_outputs("idle");
         @(negedge clk);
      end

      // Burst on channel 3 with steady pattern elsewhere, then a retrigger on channel 1.
      ld = 6'b000101; blk_req = 6'b001000; blk_cnt = 4'd2;
      @(posedge clk); model_edge(); #1; check_outputs("burst3");
      @(negedge clk);
      blk_req = '0; fl = 6'b000001;
      for (int c = 0; c < 40; c++) begin
         if (c == 2) begin blk_req = 6'b000010; blk_cnt = 4'd3; end
         else if (c == 14) begin blk_req = 6'b000010; blk_cnt = 4'd1; end
         else if (c == 20) begin blk_req = 6'b000100; blk_cnt = 4'd0; end
         else blk_req = '0;
         @(posedge clk); model_edge(); #1; check_outputs("directed");
         @(negedge clk);
      end

      // Randomised traffic with occasional lamp test and asynchronous resets.
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 399) == 0 && c > 0) begin
            async_reset_check();
         end
         if ($urandom_range(0, 19) == 0) ld = N'($urandom);
         if ($urandom_range(0, 19) == 0) fl = N'($urandom);
         if ($urandom_range(0, 29) == 0) lamp_test = ~lamp_test;
         blk_req = '0;
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 39) == 0) blk_req[i] = 1'b1;
         blk_cnt = ($urandom_range(0, 7) == 0) ? BW'($urandom) : BW'($urandom_range(0, 4));
         @(posedge clk); model_edge(); #1; check_outputs("rand");
         @(negedge clk);
      end

      blk_req = '0;
      async_reset_check();
      @(posedge clk); model_edge(); #1; check_outputs("post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/led_bank.md
Name: led_bank

Overview:
- Parametrised N-channel status-LED driver for the washer front panel.
- Successor to the fixed six-LED driver.
- Each channel can be steady-on, flashing, or run a counted blink burst.
- Lamp-test override lights every LED.
- Flashing comes from an internal half-period counter and a phase register. No divided clock is used and nothing is clock-gated. All outputs are registered in the clk domain.
- Sits between the controller FSM (ld/fl/burst requests) and the panel pins.

Parameters:
- N, 6, number of LED channels (1..32).
- FLA_CMAX, 25000000, flash half-period in clk cycles (500 ms at 50 MHz); must be >= 2.
- BW, 4, width of the burst-count input.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- ld  input  N  per-channel steady-on request.
- fl  input  N  per-channel flash request; overrides ld.
- blk_req  input  N  per-channel single-cycle burst start strobe.
- blk_cnt  input  BW  number of blinks for a burst; shared by all channels and sampled with blk_req.
- lamp_test  input  1  forces all LEDs on.
- led  output  N  LED drive, registered, active-high.
- blk_busy  output  N  channel is in burst WAIT or RUN.
- phase  output  1  current flash phase (1 = lit half), for panel-wide sync.

Behaviour:
- Reset (rst_n=0, async):
  - cnt=0, phase=0, led=0, blk_busy=0.
  - All burst FSMs IDLE; all brem=0.
  - Reset mid-burst aborts the burst with no residue.
- Phase generator:
  - cnt counts 0..FLA_CMAX-1 every clk; CW=$clog2(FLA_CMAX) bits.
  - When cnt==FLA_CMAX-1: cnt<=0, phase<=~phase; that cycle is a tick.
  - rise = tick with phase==0; fall = tick with phase==1.
  - First rise occurs FLA_CMAX cycles after reset release.
- Per-channel burst FSM (states IDLE, WAIT, RUN; brem is BW bits):
  - IDLE: blk_req[i] with blk_cnt!=0 -> brem<=blk_cnt, go WAIT. blk_cnt==0 is ignored.
  - WAIT: on rise -> RUN.
  - RUN: on fall -> brem<=brem-1. If brem==1 -> IDLE.
  - blk_req[i] with blk_cnt!=0 in WAIT or RUN: brem<=blk_cnt, state unchanged (retrigger restarts the count). This takes precedence over a same-cycle decrement or exit.
  - blk_busy[i] = (state != IDLE), registered with the state.
  - ld/fl do not affect the FSM.
- Output mux, registered, 1-cycle latency from inputs; priority high to low:
  - lamp_test -> 1
  - RUN -> next-phase value
  - fl[i] -> next-phase value
  - ld[i] -> 1
  - else 0
- WAIT behaves as the underlying ld/fl.
- All flashing channels share phase and stay in lockstep.
- led changes on the same edge as phase, so there is no glitch or skew between channels.
- A burst of k shows exactly k lit half-periods, each FLA_CMAX cycles, starting on a rise boundary.
- N=1 and BW=1 must elaborate.

Test Plan (FLA_CMAX=4, N=6, BW=4):
1. Reset release, all inputs 0 -> led=0, phase=0. Phase toggles at cycles 4, 8, 12 (full period 8 cycles). blk_busy=0 throughout.
2. ld=6'b000101 at cycle 2 -> led=000101 from cycle 3. Then fl[0]=1 -> led[0] tracks phase (4 on / 4 off) and led[2] stays 1.
3. blk_req[3] pulse with blk_cnt=2 at phase=1 -> blk_busy[3]=1 immediately. WAIT until the next rise, then exactly 2 lit 4-cycle pulses on led[3]. blk_busy[3] drops on the second fall; led[3] then returns to ld[3]=0.
4. Retrigger: blk_req[1] with blk_cnt=3, then a second blk_req[1] with blk_cnt=1 during the first lit half -> burst ends at the end of that lit half. blk_req with blk_cnt=0 in IDLE -> no change.
5. lamp_test=1 during an active burst -> led=6'b111111, and the burst continues counting underneath. Release -> led resumes burst/ld/fl pattern within 1 cycle.
6. rst_n asserted async mid-RUN on channel 4 -> led and blk_busy 0 with no clk edge. After release, no residual burst and phase restarts at 0.
